// File: rtl/term_pkg.sv
// Shared state encoding, screen geometry and control codes for term_writer.
// The escape states and escape letters exist only when TERM_ESC_EN is defined.
package term_pkg;

  localparam int          COLS     = 80;
  localparam int          LAST_ROW = 24;
  localparam logic [15:0] BLANK    = 16'h2020;
  localparam logic [10:0] END_OFF  = 11'd2000;
  localparam logic [10:0] LAST_OFF = 11'(LAST_ROW * COLS);

  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_FF = 8'h0C;
  localparam logic [7:0] C_CR = 8'h0D;
`ifdef TERM_ESC_EN
  localparam logic [7:0] C_ESC = 8'h1B;
  localparam logic [7:0] C_Y   = 8'h59;
  localparam logic [7:0] C_H   = 8'h48;
  localparam logic [7:0] C_J   = 8'h4A;
`endif

  typedef enum logic [2:0] {
    IDLE, PUTC, SCR_RD, SCR_WR, CLR
`ifdef TERM_ESC_EN
    , ESC, ESC_ROW, ESC_COL
`endif
  } state_t;

  function automatic logic [1:0] byte_sel(input logic odd);
    return odd ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [10:0] offset_of(input logic [4:0] row, input logic [6:0] col);
    return 11'(row) * 11'(COLS) + 11'(col);
  endfunction

endpackage

// File: rtl/term_wbm.sv
// Single-transfer Wishbone master: launches on i_req while idle, holds cyc/stb
// until ack, reports completion combinationally on the ack cycle.
module term_wbm
  import term_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_adr,
  input  logic [15:0] i_dat,
  input  logic [1:0]  i_sel,
  output logic        o_done,
  output logic [15:0] o_rdata,
  output logic [15:0] o_wb_adr,
  output logic [15:0] o_wb_dat,
  input  logic [15:0] i_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [1:0]  o_wb_sel,
  input  logic        i_wb_ack
);

  logic        r_cyc;
  logic        r_we;
  logic [15:0] r_adr;
  logic [15:0] r_dat;
  logic [1:0]  r_sel;
  logic [15:0] r_rdata;

  // A request is only taken while cyc is low, which forces the idle cycle
  // between back-to-back transfers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
    end else if (!r_cyc) begin
      if (i_req) begin
        r_cyc <= 1'b1;
        r_we  <= i_we;
        r_adr <= i_adr;
        r_dat <= i_dat;
        r_sel <= i_sel;
      end
    end else if (i_wb_ack) begin
      r_cyc   <= 1'b0;
      r_rdata <= i_wb_dat;
    end
  end

  assign o_done   = r_cyc & i_wb_ack;
  assign o_rdata  = r_rdata;
  assign o_wb_adr = r_adr;
  assign o_wb_dat = r_dat;
  assign o_wb_cyc = r_cyc;
  assign o_wb_stb = r_cyc;
  assign o_wb_we  = r_we;
  assign o_wb_sel = r_sel;

endmodule

// File: rtl/term_writer.sv
// Character-stream terminal writer into an 80x25 text RAM over Wishbone.
// Define TERM_ESC_EN to enable ESC Y/H/J cursor and clear sequences.
module term_writer
  import term_pkg::*;
#(
  parameter logic [15:0] VBASE     = 16'o0,
  parameter int          FIRST_ROW = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [7:0]  char_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  output logic [15:0] wbm_adr_o,
  output logic [15:0] wbm_dat_o,
  input  logic [15:0] wbm_dat_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [1:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  output logic [12:0] cursor_o,
  output logic        cursor_on_o,
  output logic        busy_o
);

  localparam int          COPY_WORDS = (LAST_ROW - FIRST_ROW) * 40;
  localparam logic [9:0]  COPY_LAST  = 10'(COPY_WORDS - 1);
  localparam logic [10:0] TOP_OFF    = 11'(FIRST_ROW * COLS);
  localparam logic [10:0] SRC_OFF    = 11'((FIRST_ROW + 1) * COLS);
  localparam logic [4:0]  ROW0       = 5'(FIRST_ROW);
  localparam logic [4:0]  ROWN       = 5'(LAST_ROW);

  state_t      r_state;
  logic [4:0]  r_row;
  logic [6:0]  r_col;
  logic [9:0]  r_cnt;
  logic [10:0] r_off;
  logic [10:0] r_end;
  logic        r_clr_byte;
  logic        r_clr_home;
  logic        r_alive;
`ifdef TERM_ESC_EN
  logic [4:0]  r_esc_row;
`endif

  logic        w_rdy_state;
  logic        w_accept;
  logic        w_glyph;
  logic        w_scroll_go;
  logic [10:0] w_cur_off;
  logic [10:0] w_clr_next;
  logic        w_req;
  logic        w_we;
  logic [10:0] w_off;
  logic [15:0] w_dat;
  logic [1:0]  w_sel;
  logic        w_done;
  logic [15:0] w_rdata;

`ifdef TERM_ESC_EN
  function automatic logic [4:0] clamp_row(input logic [7:0] c);
    if (c < 8'(32 + FIRST_ROW)) return ROW0;
    else if (c > 8'(32 + LAST_ROW)) return ROWN;
    else return 5'(c - 8'd32);
  endfunction

  function automatic logic [6:0] clamp_col(input logic [7:0] c);
    if (c < 8'd32) return 7'd0;
    else if (c > 8'd111) return 7'd79;
    else return 7'(c - 8'd32);
  endfunction

  assign w_rdy_state = (r_state == IDLE) || (r_state == ESC) ||
                       (r_state == ESC_ROW) || (r_state == ESC_COL);
`else
  assign w_rdy_state = (r_state == IDLE);
`endif

  // Ready is held low until the first clock after reset release.
  assign char_ready_o = r_alive & w_rdy_state;
  assign w_accept     = char_valid_i & char_ready_o;
  assign busy_o       = ~w_rdy_state;
  assign cursor_on_o  = ~((r_state == SCR_RD) || (r_state == SCR_WR) || (r_state == CLR));
  assign w_cur_off    = offset_of(r_row, r_col);
  assign cursor_o     = {2'b00, w_cur_off};
  assign w_clr_next   = r_off + (r_clr_byte ? 11'd1 : 11'd2);

  always_comb begin
    w_glyph = !(char_i == C_BS || char_i == C_LF || char_i == C_FF || char_i == C_CR);
`ifdef TERM_ESC_EN
    if (char_i == C_ESC) w_glyph = 1'b0;
`endif
  end

  assign w_scroll_go = (r_row == ROWN) &&
                       ((r_state == IDLE && w_accept && char_i == C_LF) ||
                        (r_state == PUTC && w_done && r_col == 7'd79));

  always_comb begin
    w_req = 1'b0;
    w_we  = 1'b1;
    w_off = w_cur_off;
    w_dat = {char_i, char_i};
    w_sel = byte_sel(w_cur_off[0]);
    case (r_state)
      IDLE:   w_req = w_accept & w_glyph;
      SCR_RD: begin
        w_req = 1'b1;
        w_we  = 1'b0;
        w_off = SRC_OFF + {r_cnt, 1'b0};
        w_sel = 2'b11;
      end
      SCR_WR: begin
        w_req = 1'b1;
        w_off = TOP_OFF + {r_cnt, 1'b0};
        w_dat = w_rdata;
        w_sel = 2'b11;
      end
      CLR: begin
        w_req = 1'b1;
        w_off = r_off;
        w_dat = BLANK;
        w_sel = r_clr_byte ? byte_sel(r_off[0]) : 2'b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state    <= IDLE;
      r_row      <= ROW0;
      r_col      <= '0;
      r_cnt      <= '0;
      r_off      <= '0;
      r_end      <= '0;
      r_clr_byte <= 1'b0;
      r_clr_home <= 1'b0;
      r_alive    <= 1'b0;
`ifdef TERM_ESC_EN
      r_esc_row  <= ROW0;
`endif
    end else begin
      r_alive <= 1'b1;
      case (r_state)
        IDLE: if (w_accept) begin
          if (char_i == C_CR) r_col <= '0;
          else if (char_i == C_BS) begin
            if (r_col != 7'd0) r_col <= r_col - 7'd1;
          end else if (char_i == C_LF) begin
            if (r_row != ROWN) r_row <= r_row + 5'd1;
          end else if (char_i == C_FF) begin
            r_off      <= TOP_OFF;
            r_end      <= END_OFF;
            r_clr_byte <= 1'b0;
            r_clr_home <= 1'b1;
            r_state    <= CLR;
          end
`ifdef TERM_ESC_EN
          else if (char_i == C_ESC) r_state <= ESC;
`endif
          else r_state <= PUTC;
        end
        PUTC: if (w_done) begin
          r_state <= IDLE;
          if (r_col == 7'd79) begin
            r_col <= '0;
            if (r_row != ROWN) r_row <= r_row + 5'd1;
          end else begin
            r_col <= r_col + 7'd1;
          end
        end
        SCR_RD: if (w_done) r_state <= SCR_WR;
        SCR_WR: if (w_done) begin
          if (r_cnt == COPY_LAST) begin
            r_off      <= LAST_OFF;
            r_end      <= END_OFF;
            r_clr_byte <= 1'b0;
            r_clr_home <= 1'b0;
            r_state    <= CLR;
          end else begin
            r_cnt   <= r_cnt + 10'd1;
            r_state <= SCR_RD;
          end
        end
        CLR: if (w_done) begin
          if (w_clr_next >= r_end) begin
            r_state <= IDLE;
            if (r_clr_home) begin
              r_row <= ROW0;
              r_col <= '0;
            end
          end else begin
            r_off <= w_clr_next;
          end
        end
`ifdef TERM_ESC_EN
        ESC: if (w_accept) begin
          if (char_i == C_Y) r_state <= ESC_ROW;
          else if (char_i == C_H) begin
            r_row   <= ROW0;
            r_col   <= '0;
            r_state <= IDLE;
          end else if (char_i == C_J) begin
            r_off      <= w_cur_off;
            r_end      <= END_OFF;
            r_clr_byte <= 1'b1;
            r_clr_home <= 1'b0;
            r_state    <= CLR;
          end else r_state <= IDLE;
        end
        ESC_ROW: if (w_accept) begin
          r_esc_row <= clamp_row(char_i);
          r_state   <= ESC_COL;
        end
        ESC_COL: if (w_accept) begin
          r_row   <= r_esc_row;
          r_col   <= clamp_col(char_i);
          r_state <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
      // Line feed at the bottom row, from either a LF or a wrapping glyph.
      if (w_scroll_go) begin
        if (COPY_WORDS != 0) begin
          r_cnt   <= '0;
          r_state <= SCR_RD;
        end else begin
          r_off      <= LAST_OFF;
          r_end      <= END_OFF;
          r_clr_byte <= 1'b0;
          r_clr_home <= 1'b0;
          r_state    <= CLR;
        end
      end
    end
  end

  term_wbm u_wbm (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_n_i),
    .i_req    (w_req),
    .i_we     (w_we),
    .i_adr    (VBASE + {5'b00000, w_off}),
    .i_dat    (w_dat),
    .i_sel    (w_sel),
    .o_done   (w_done),
    .o_rdata  (w_rdata),
    .o_wb_adr (wbm_adr_o),
    .o_wb_dat (wbm_dat_o),
    .i_wb_dat (wbm_dat_i),
    .o_wb_cyc (wbm_cyc_o),
    .o_wb_stb (wbm_stb_o),
    .o_wb_we  (wbm_we_o),
    .o_wb_sel (wbm_sel_o),
    .i_wb_ack (wbm_ack_i)
  );

endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer with a one-cycle-ack video RAM slave.
// Escape-sequence steps run when TERM_ESC_EN is defined.
`timescale 1ns/1ps
module tb_term_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ch = 8'h00;
  logic        ch_valid = 1'b0;
  logic        char_ready_o;
  logic [15:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [1:0]  wbm_sel_o;
  logic        ack_r;
  logic [12:0] cursor_o;
  logic        cursor_on_o, busy_o;

  always #5 clk = ~clk;

  term_writer dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .char_i(ch), .char_valid_i(ch_valid), .char_ready_o(char_ready_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_ack_i(ack_r),
    .cursor_o(cursor_o), .cursor_on_o(cursor_on_o), .busy_o(busy_o)
  );

  // Video RAM slave with a transfer log.
  logic [15:0] mem [0:1023];
  logic [33:0] wr_log [0:8191];
  logic [15:0] rd_log [0:4095];
  int          wr_n = 0;
  int          rd_n = 0;
  logic        preload = 1'b0;

  assign wbm_dat_i = mem[wbm_adr_o[10:1]];

  always @(posedge clk) begin
    if (preload)
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h1000 + 16'(i);
    if (!rst_n) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= wbm_cyc_o & wbm_stb_o & ~ack_r;
      if (wbm_cyc_o & wbm_stb_o & ack_r) begin
        if (wbm_we_o) begin
          if (wbm_sel_o[0]) mem[wbm_adr_o[10:1]][7:0]  <= wbm_dat_o[7:0];
          if (wbm_sel_o[1]) mem[wbm_adr_o[10:1]][15:8] <= wbm_dat_o[15:8];
          wr_log[wr_n[12:0]] <= {wbm_adr_o, wbm_sel_o, wbm_dat_o};
          wr_n <= wr_n + 1;
        end else begin
          rd_log[rd_n[11:0]] <= wbm_adr_o;
          rd_n <= rd_n + 1;
        end
      end
    end
  end

  int   checks = 0;
  int   errors = 0;
  logic ack_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1ns after the edge, with bus protocol checks.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("stb_eq_cyc", 64'(wbm_stb_o), 64'(wbm_cyc_o));
      if (ack_prev) chk("cyc_drop_after_ack", 64'(wbm_cyc_o), 64'd0);
      ack_prev = ack_r & wbm_cyc_o;
    end else begin
      ack_prev = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    while (!char_ready_o && n < 5000) begin tick(); n++; end
    if (!char_ready_o) chk("ready_timeout", 64'(char_ready_o), 64'd1);
    ch = c;
    ch_valid = 1'b1;
    tick();
    ch_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || wbm_cyc_o) && n < 20000) begin tick(); n++; end
    chk("idle_timeout", 64'(busy_o), 64'd0);
  endtask

  function automatic logic [7:0] glyph(input int i);
    if (i == 5) return 8'h01;
`ifndef TERM_ESC_EN
    if (i == 6) return 8'h1B;
`endif
    return 8'h41 + 8'(i % 26);
  endfunction

  initial begin
    int w0, r0, bad, n;
    ch_valid = 1'b0;
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("rst_stb", 64'(wbm_stb_o), 64'd0);
    chk("rst_we", 64'(wbm_we_o), 64'd0);
    chk("rst_sel", 64'(wbm_sel_o), 64'd0);
    chk("rst_adr", 64'(wbm_adr_o), 64'd0);
    chk("rst_dat", 64'(wbm_dat_o), 64'd0);
    chk("rst_cursor", 64'(cursor_o), 64'd80);
    chk("rst_cursor_on", 64'(cursor_on_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(char_ready_o), 64'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("ready_after_rst", 64'(char_ready_o), 64'd1);

    // 'A' with cycle-exact latency
    w0 = wr_n;
    ch = 8'h41; ch_valid = 1'b1;
    tick();
    ch_valid = 1'b0;
    chk("a_stb_n1", 64'(wbm_stb_o), 64'd1);
    chk("a_ready_n1", 64'(char_ready_o), 64'd0);
    chk("a_cursor_n1", 64'(cursor_o), 64'd80);
    tick();
    chk("a_stb_n2", 64'(wbm_stb_o), 64'd1);
    chk("a_cursor_n2", 64'(cursor_o), 64'd80);
    tick();
    chk("a_cyc_n3", 64'(wbm_cyc_o), 64'd0);
    chk("a_cursor_n3", 64'(cursor_o), 64'd81);
    chk("a_ready_n3", 64'(char_ready_o), 64'd1);
    chk("a_wr_count", 64'(wr_n - w0), 64'd1);
    chk("a_wr", 64'(wr_log[w0]), {30'd0, 16'd80, 2'b01, 16'h4141});

    // CR, then BS at column 0
    send(8'h0D);
    chk("cr_cursor", 64'(cursor_o), 64'd80);
    send(8'h08);
    chk("bs_col0_cursor", 64'(cursor_o), 64'd80);
    chk("cr_bs_no_bus", 64'(wr_n - w0), 64'd1);

    // 80 glyphs across row 1, wrapping to row 2
    w0 = wr_n;
    for (int i = 0; i < 80; i++) send(glyph(i));
    wait_idle();
    chk("row_wr_count", 64'(wr_n - w0), 64'd80);
    chk("row_ctrl_glyph", 64'(wr_log[w0 + 5]), {30'd0, 16'd85, 2'b10, 16'h0101});
`ifndef TERM_ESC_EN
    chk("row_esc_glyph", 64'(wr_log[w0 + 6]), {30'd0, 16'd86, 2'b01, 16'h1B1B});
`endif
    chk("row_last_wr", 64'(wr_log[w0 + 79]), {30'd0, 16'd159, 2'b10, 16'h4242});
    chk("row_wrap_cursor", 64'(cursor_o), 64'd160);

    // Glyph then BS
    send(8'h78);
    wait_idle();
    chk("x_cursor", 64'(cursor_o), 64'd161);
    chk("x_wr", 64'(wr_log[wr_n - 1]), {30'd0, 16'd160, 2'b01, 16'h7878});
    send(8'h08);
    chk("bs_cursor", 64'(cursor_o), 64'd160);

    // LF down to the bottom row: no bus traffic
    w0 = wr_n;
    for (int i = 0; i < 22; i++) send(8'h0A);
    chk("lf_cursor", 64'(cursor_o), 64'd1920);
    chk("lf_no_bus", 64'(wr_n - w0), 64'd0);

    // LF on the bottom row scrolls
    w0 = wr_n; r0 = rd_n; bad = 0; n = 0;
    send(8'h0A);
    while (busy_o && n < 30000) begin
      if (cursor_on_o !== 1'b0 || cursor_o !== 13'd1920) bad++;
      tick(); n++;
    end
    chk("scroll_done", 64'(busy_o), 64'd0);
    chk("scroll_cursor_during", 64'(bad), 64'd0);
    chk("scroll_rd_count", 64'(rd_n - r0), 64'd920);
    chk("scroll_wr_count", 64'(wr_n - w0), 64'd960);
    chk("scroll_first_rd", 64'(rd_log[r0]), 64'd160);
    chk("scroll_last_rd", 64'(rd_log[r0 + 919]), 64'd1998);
    chk("scroll_first_wr", 64'(wr_log[w0]), {30'd0, 16'd80, 2'b11, 16'h1078});
    chk("scroll_last_copy", 64'(wr_log[w0 + 919]), {30'd0, 16'd1918, 2'b11, 16'h13E7});
    chk("scroll_first_blank", 64'(wr_log[w0 + 920]), {30'd0, 16'd1920, 2'b11, 16'h2020});
    chk("scroll_last_blank", 64'(wr_log[w0 + 959]), {30'd0, 16'd1998, 2'b11, 16'h2020});
    chk("scroll_cursor_after", 64'(cursor_o), 64'd1920);
    chk("scroll_cursor_on_after", 64'(cursor_on_o), 64'd1);

    // Form feed clears rows 1..24 and homes
    w0 = wr_n; r0 = rd_n; bad = 0;
    send(8'h0C);
    wait_idle();
    chk("ff_wr_count", 64'(wr_n - w0), 64'd960);
    chk("ff_rd_count", 64'(rd_n - r0), 64'd0);
    for (int i = 0; i < 960; i++)
      if (wr_log[w0 + i] !== {16'(80 + 2 * i), 2'b11, 16'h2020}) bad++;
    chk("ff_wr_pattern", 64'(bad), 64'd0);
    chk("ff_cursor", 64'(cursor_o), 64'd80);

`ifdef TERM_ESC_EN
    w0 = wr_n;
    send(8'h1B); send(8'h59); send(8'h2A); send(8'h45);
    chk("esc_y_cursor", 64'(cursor_o), 64'd837);
    send(8'h1B); send(8'h59); send(8'h7F); send(8'h7F);
    chk("esc_y_clamp_hi", 64'(cursor_o), 64'd1999);
    send(8'h1B); send(8'h59); send(8'h20); send(8'h10);
    chk("esc_y_clamp_lo", 64'(cursor_o), 64'd80);
    chk("esc_y_no_bus", 64'(wr_n - w0), 64'd0);
    send(8'h1B); send(8'h59); send(8'h38); send(8'h6E);
    send(8'h1B); send(8'h4A);
    wait_idle();
    chk("esc_j_count", 64'(wr_n - w0), 64'd2);
    chk("esc_j_wr0", 64'(wr_log[w0]), {30'd0, 16'd1998, 2'b01, 16'h2020});
    chk("esc_j_wr1", 64'(wr_log[w0 + 1]), {30'd0, 16'd1999, 2'b10, 16'h2020});
    chk("esc_j_cursor", 64'(cursor_o), 64'd1998);
    send(8'h1B); send(8'h48);
    chk("esc_h_cursor", 64'(cursor_o), 64'd80);
    send(8'h1B); send(8'h51);
    chk("esc_other_ready", 64'(char_ready_o), 64'd1);
    chk("esc_other_no_bus", 64'(wr_n - w0), 64'd2);
`else
    w0 = wr_n;
    send(8'h1B);
    wait_idle();
    chk("esc_glyph_wr", 64'(wr_log[w0]), {30'd0, 16'd80, 2'b01, 16'h1B1B});
    chk("esc_glyph_cursor", 64'(cursor_o), 64'd81);
    send(8'h0D);
`endif

    // Reset in the middle of a scroll
    for (int i = 0; i < 23; i++) send(8'h0A);
    chk("pre_rst_cursor", 64'(cursor_o), 64'd1920);
    r0 = rd_n; n = 0;
    send(8'h0A);
    while ((rd_n - r0) < 500 && n < 10000) begin tick(); n++; end
    while (!wbm_cyc_o && n < 10010) begin tick(); n++; end
    chk("scroll_in_flight", 64'(wbm_cyc_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("mid_rst_stb", 64'(wbm_stb_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_cursor_on", 64'(cursor_on_o), 64'd1);
    tick();
    chk("mid_rst_ready_held", 64'(char_ready_o), 64'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_cursor", 64'(cursor_o), 64'd80);
    chk("post_rst_busy", 64'(busy_o), 64'd0);
    chk("post_rst_ready", 64'(char_ready_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/term_writer.md
TERM_WRITER -- requirements
Module: term_writer

Interface
REQ-001 SHALL have parameter VBASE, default 16'o0: bus byte address of video RAM offset 0.
REQ-002 SHALL have parameter FIRST_ROW, default 1: first text row managed; rows below it (status line) are never written.
REQ-003 SHALL have port wb_clk_i, input, 1: the single clock, rising edge.
REQ-004 SHALL have port wb_rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports char_i (input, 8), char_valid_i (input, 1) and char_ready_o (output, 1): the character stream in, with its handshake.
REQ-006 SHALL have wishbone master ports wbm_adr_o (out, 16), wbm_dat_o (out, 16), wbm_dat_i (in, 16), wbm_cyc_o (out, 1), wbm_stb_o (out, 1), wbm_we_o (out, 1), wbm_sel_o (out, 2) and wbm_ack_i (in, 1).
REQ-007 SHALL have ports cursor_o (out, 13), the byte offset row*80+col, and cursor_on_o (out, 1), the cursor-visible flag.
REQ-008 SHALL have port busy_o, output, 1: high in any state other than IDLE, ESC, ESC_ROW and ESC_COL.

Function
REQ-009 Screen: 80 cols x 25 rows; col 0..79; row FIRST_ROW..24.
REQ-010 A character is accepted on the cycle where char_valid_i & char_ready_o; char_ready_o is high only in IDLE, ESC, ESC_ROW and ESC_COL.
REQ-011 States: IDLE, PUTC, ESC, ESC_ROW, ESC_COL, SCR_RD, SCR_WR, CLR.
REQ-012 Bus rules: single transfers; cyc and stb asserted together and held until ack; both dropped the cycle after ack is sampled; at least 1 idle cycle between transfers.
REQ-013 Address: wbm_adr_o = VBASE + byte offset. For a byte write, wbm_sel_o = offset[0] ? 2'b10 : 2'b01 and wbm_dat_o = {c,c}. For a word transfer, sel = 2'b11 and the address is even.
REQ-014 Printable (IDLE, code not 08/0A/0D/0C/1B): PUTC writes the byte at the cursor. On ack, col++; if col was 79, col <- 0 and LF is applied.
REQ-015 Codes 00-1F other than 08/0A/0C/0D/1B are written as glyphs.
REQ-016 Code 0D: col <- 0; no bus cycle.
REQ-017 Code 08: col-- if col > 0, else no change; no bus cycle.
REQ-018 Code 0A: if row < 24, row++; if row == 24, scroll.
REQ-019 Scroll: for w = 0 .. (24-FIRST_ROW)*40-1, read the word at (FIRST_ROW+1)*80 + 2w (SCR_RD), then write it to FIRST_ROW*80 + 2w (SCR_WR). Then CLR writes 16'h2020 to 40 words from offset 1920. Cursor row is unchanged.
REQ-020 Code 0C: CLR fills rows FIRST_ROW..24 with 16'h2020; then row <- FIRST_ROW and col <- 0.
REQ-021 cursor_on_o is 0 in SCR_RD, SCR_WR and CLR, and 1 otherwise.
REQ-022 Latency for a printable accepted at cycle N: stb rises at N+1; with ack at N+2, cursor_o updates at N+3 and char_ready_o is high at N+3.
REQ-023 The word counter and the copy counter are sized to hold 1000 without overflow.

Reset
REQ-024 wb_rst_n_i low immediately, even mid-transfer or mid-scroll, forces: state IDLE; cyc, stb and we = 0; sel = 0; adr = 0; dat = 0; row = FIRST_ROW; col = 0; cursor_on_o = 1; busy_o = 0; char_ready_o = 0 while reset is held.
REQ-025 Video RAM contents are not cleared by reset.

Configuration
REQ-026 Macro TERM_ESC_EN defined: 1B moves IDLE to ESC.
- ESC 'Y' r c: row = r-32 clamped to [FIRST_ROW,24]; col = c-32 clamped to [0,79].
- ESC 'H': home.
- ESC 'J': clear from cursor to end of screen, byte-wise.
- Any other byte after ESC: discarded, back to IDLE.
REQ-027 TERM_ESC_EN undefined: 1B is written as a glyph; states ESC, ESC_ROW and ESC_COL do not exist.

Structure
REQ-028 Shared package term_pkg holds:
- state enum;
- constants COLS = 80, LAST_ROW = 24, BLANK = 16'h2020;
- control-code constants.
REQ-029 One sub-module, term_wbm: single-transfer wishbone master FSM (req/we/adr/dat/sel in; done/rdata out), reused by PUTC, SCR and CLR.

Verification
REQ-030 Reset, then 'A' (8'h41) with an ack-1-cycle slave -> one write: adr=80, sel=01, dat=4141; cursor_o 80 -> 81; ready returns at N+3.
REQ-031 Feed 80 printables from row 1 -> last write adr=159, sel=10; cursor_o=160 (col 0, row 2).
REQ-032 Cursor at row 24, send 0A -> 920 reads/920 writes; first read adr=160, write adr=80; last write adr=1918. Then 40 writes of 2020 ending adr=1998. busy_o high throughout, cursor_on_o=0, cursor_o stays 1920.
REQ-033 Send 0C -> 960 word writes of 2020 from adr 80; then cursor_o=80.
REQ-034 With TERM_ESC_EN: 1B 59 2A 45 -> cursor_o = 10*80+37 = 837, no bus cycle. 1B 59 7F 7F -> cursor_o = 1999.
REQ-035 Assert wb_rst_n_i low at word 500 of a scroll -> cyc=0 in the same cycle; after release, cursor_o=80, busy_o=0, char_ready_o=1.
